execute_stage: RTL
==================

// Module: execute_stage
// PURPOSE
//  EX stage of the 5-stage MIPS32 pipeline: holds the ID/EX register, computes ALU result,
//  branch target, jump target and zero flag, and drives the *_e inputs of the memory stage.
//  Owns the HI/LO registers and a multi-cycle multiply/divide unit. A dependent instruction
//  waits in ID/EX while the unit is busy; the hazard unit receives a stall request.
// PARAMETERS
//  MUL_CYCLES  4   busy cycles for MULT/MULTU after issue (>=1); product delayed through a shift chain
// PORTS
//  clk             in   1   clock
//  rst             in   1   synchronous active-high reset
//  flush_e         in   1   load bubble into ID/EX (branch taken in MEM)
//  reg_write_d, mem_to_reg_d, mem_write_d, branch_d   in  1 each  decode control
//  alu_ctrl_d      in   4   0 AND,1 OR,2 ADD,3 XOR,4 NOR,6 SUB,7 SLT,8 SLTU,9 SLL,A SRL,B SRA,C LUI,D MFHI,E MFLO
//  md_op_d         in   3   0 none,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MTHI,6 MTLO
//  branch_type_d   in   4   passed through (1 J,2 JAL,3 JR,4 BEQ,5 BNE,6 BGEZ,7 BLTZ)
//  src_a_d, src_b_d in  32  operands (forwarded upstream); src_b already imm-muxed
//  rt_data_d       in   32  store data
//  shamt_d         in   5   shift amount
//  imm_d           in   32  sign-extended immediate
//  pc_plus4_d      in   32  PC+4
//  instr_index_d   in   26  J-type target field
//  write_reg_d     in   5   destination GPR
//  reg_write_e, mem_to_reg_e, mem_write_e, branch_e  out 1   to memory stage
//  alu_out_e       out  32  ALU result
//  write_data_e    out  32  store data
//  write_reg_e     out  5   destination
//  zero_e          out  1   alu_out_e == 0
//  pc_branch_e     out  32  pc_plus4 + (imm<<2), mod 2^32
//  jump_addr_e     out  32  {pc_plus4[31:28], instr_index, 2'b00}
//  branch_type_e   out  4   registered branch type
//  stall_e         out  1   hold IF/ID/ID-EX this cycle
// BEHAVIOUR
//  - ID/EX register: on rst or flush_e (no stall_e) loads bubble (all controls 0, md_op 0,
//    alu_ctrl 0, data 0). Else if stall_e=0 loads *_d; if stall_e=1 holds. flush_e with stall_e=1: flush wins.
//  - All *_e outputs combinational from ID/EX + HI/LO. While stall_e=1, reg_write_e,
//    mem_write_e, branch_e, mem_to_reg_e forced 0 (bubble to MEM); data outputs don't-care.
//  - Reset: ID/EX = bubble, HI=LO=0, FSM IDLE, stall_e=0, all control outputs 0.
//  - Shifts use shamt_d on src_b; SLT signed, SLTU unsigned; LUI = {src_b[15:0],16'h0}.
//  - FSM IDLE/MUL/DIV. Leaving ID/EX with md_op 1-4 (stall_e=0) -> MUL (count MUL_CYCLES)
//    or DIV (33 cycles: 32 restoring iterations + sign fix). Issuing instruction itself goes to
//    MEM as normal (no GPR write). Counter hits 0 -> HI/LO written that edge, back to IDLE.
//  - MULT signed 64-bit product, MULTU unsigned; HI=prod[63:32], LO=prod[31:0].
//  - DIV/DIVU: LO=quotient (trunc toward zero), HI=remainder (sign of dividend).
//    Divisor 0: LO=32'hFFFF_FFFF, HI=dividend. DIV 32'h8000_0000/-1: LO=32'h8000_0000, HI=0.
//  - MTHI/MTLO write HI/LO at end of their EX cycle; MFHI/MFLO read current HI/LO.
//  - stall_e = (state!=IDLE) && ID/EX holds md_op!=0 or alu_ctrl MFHI/MFLO. Independent
//    instructions proceed during a busy operation. stall_e drops the cycle HI/LO are written
//    (dependent op sees new value the next cycle).
//  - flush_e never aborts an in-flight md op; rst aborts it, HI/LO=0.
// CONFIGURATION
//  EXEC_DIV_EN defined: DIV/DIVU supported as above.
//  Undefined: DIV FSM state and divider logic removed; md_op 3/4 behave as md_op 0
//    (HI/LO unchanged, no busy, no stall).
// TESTING
//  1 ADD src_a=7,src_b=-7 -> alu_out_e=0, zero_e=1; SUB 5-9 -> 32'hFFFF_FFFC, zero_e=0.
//  2 BEQ pc_plus4=0x100, imm=-2 -> pc_branch_e=0xF8, branch_type_e=4; J index 0x40 -> jump_addr_e=0x100.
//  3 MULT -3*5 then MFLO next: stall_e=1 for MUL_CYCLES cycles, bubbles to MEM, then alu_out_e=32'hFFFF_FFF1; MFHI -> 32'hFFFF_FFFF.
//  4 DIV -7/2 then MFHI (EXEC_DIV_EN) -> LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF; DIVU 9/0 -> LO=32'hFFFF_FFFF, HI=9.
//  5 MULT then independent ADD/SW: no stall, SW reaches MEM next cycle with mem_write_e=1.
//  6 rst asserted mid-DIV -> next cycle stall_e=0, HI=LO=0, controls 0; flush_e with stall -> ID/EX bubble.

Source files
------------

// File: rtl/execute_stage.sv
// MIPS32 EX stage: ID/EX register, ALU, branch/jump targets, HI/LO and a multi-cycle mul/div unit.
// Define EXEC_DIV_EN to build in the DIV/DIVU restoring divider; otherwise md_op 3/4 are no-ops.
module execute_stage #(
    parameter int MUL_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_e,
    input  logic        reg_write_d,
    input  logic        mem_to_reg_d,
    input  logic        mem_write_d,
    input  logic        branch_d,
    input  logic [3:0]  alu_ctrl_d,
    input  logic [2:0]  md_op_d,
    input  logic [3:0]  branch_type_d,
    input  logic [31:0] src_a_d,
    input  logic [31:0] src_b_d,
    input  logic [31:0] rt_data_d,
    input  logic [4:0]  shamt_d,
    input  logic [31:0] imm_d,
    input  logic [31:0] pc_plus4_d,
    input  logic [25:0] instr_index_d,
    input  logic [4:0]  write_reg_d,
    output logic        reg_write_e,
    output logic        mem_to_reg_e,
    output logic        mem_write_e,
    output logic        branch_e,
    output logic [31:0] alu_out_e,
    output logic [31:0] write_data_e,
    output logic [4:0]  write_reg_e,
    output logic        zero_e,
    output logic [31:0] pc_branch_e,
    output logic [31:0] jump_addr_e,
    output logic [3:0]  branch_type_e,
    output logic        stall_e
);

    localparam logic [3:0] ALU_AND  = 4'h0, ALU_OR   = 4'h1, ALU_ADD  = 4'h2, ALU_XOR = 4'h3,
                           ALU_NOR  = 4'h4, ALU_SUB  = 4'h6, ALU_SLT  = 4'h7, ALU_SLTU = 4'h8,
                           ALU_SLL  = 4'h9, ALU_SRL  = 4'hA, ALU_SRA  = 4'hB, ALU_LUI = 4'hC,
                           ALU_MFHI = 4'hD, ALU_MFLO = 4'hE;
    localparam logic [2:0] MD_MULT = 3'd1, MD_MULTU = 3'd2, MD_MTHI = 3'd5, MD_MTLO = 3'd6;
`ifdef EXEC_DIV_EN
    localparam logic [2:0] MD_DIV = 3'd3, MD_DIVU = 3'd4;
`endif
    localparam int CNT_W = (MUL_CYCLES > 32) ? $clog2(MUL_CYCLES) + 1 : 6;

    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg;
        logic        mem_write;
        logic        branch;
        logic [3:0]  alu_ctrl;
        logic [2:0]  md_op;
        logic [3:0]  branch_type;
        logic [31:0] src_a;
        logic [31:0] src_b;
        logic [31:0] rt_data;
        logic [4:0]  shamt;
        logic [31:0] imm;
        logic [31:0] pc_plus4;
        logic [25:0] instr_index;
        logic [4:0]  write_reg;
    } idex_t;

    localparam idex_t BUBBLE = '0;

`ifdef EXEC_DIV_EN
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;
`else
    typedef enum logic [0:0] {S_IDLE, S_MUL} state_t;
`endif

    idex_t             idex, idex_d;
    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt;
    logic              busy, mul_done, md_dep, hilo_dep, issue_mul;
    logic [31:0]       hi, lo, alu_result;
    logic              mul_signed;
    logic [63:0]       mul_a_ext, mul_b_ext, mul_product;
    logic [63:0]       mul_chain [MUL_CYCLES];
`ifdef EXEC_DIV_EN
    logic              div_done, issue_div, div_signed, div_a_neg, div_b_neg, div_q_neg, div_r_neg;
    logic [31:0]       div_a_mag, div_b_mag, div_quo, div_rem, div_dvsr, div_dvnd, div_lo, div_hi;
    logic [32:0]       div_shift, div_diff;
`endif

    assign idex_d = '{reg_write_d, mem_to_reg_d, mem_write_d, branch_d, alu_ctrl_d, md_op_d,
                      branch_type_d, src_a_d, src_b_d, rt_data_d, shamt_d, imm_d, pc_plus4_d,
                      instr_index_d, write_reg_d};

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || flush_e) idex <= BUBBLE;
        else if (!stall_e)  idex <= idex_d;
    end

    // Instructions that read or write HI/LO must wait while the unit is busy.
    always_comb begin
        md_dep = 1'b0;
        case (idex.md_op)
            MD_MULT, MD_MULTU, MD_MTHI, MD_MTLO: md_dep = 1'b1;
`ifdef EXEC_DIV_EN
            MD_DIV, MD_DIVU:                     md_dep = 1'b1;
`endif
            default:                             md_dep = 1'b0;
        endcase
    end

    assign hilo_dep  = md_dep || (idex.alu_ctrl == ALU_MFHI) || (idex.alu_ctrl == ALU_MFLO);
    assign stall_e   = busy && hilo_dep;
    assign issue_mul = !stall_e && ((idex.md_op == MD_MULT) || (idex.md_op == MD_MULTU));
`ifdef EXEC_DIV_EN
    assign issue_div = !stall_e && ((idex.md_op == MD_DIV) || (idex.md_op == MD_DIVU));
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (issue_mul) state_next = S_MUL;
`ifdef EXEC_DIV_EN
                else if (issue_div) state_next = S_DIV;
`endif
            end
            S_MUL: if (cnt == '0) state_next = S_IDLE;
`ifdef EXEC_DIV_EN
            S_DIV: if (cnt == '0) state_next = S_IDLE;
`endif
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = 1'b0;
        mul_done = 1'b0;
`ifdef EXEC_DIV_EN
        div_done = 1'b0;
`endif
        case (state)
            S_MUL: begin
                busy     = 1'b1;
                mul_done = (cnt == '0);
            end
`ifdef EXEC_DIV_EN
            S_DIV: begin
                busy     = 1'b1;
                div_done = (cnt == '0);
            end
`endif
            default: ;
        endcase
    end

    // Counter holds remaining busy cycles minus one; HI/LO are written when it reaches zero.
    always_ff @(posedge clk) begin
        if (rst)            cnt <= '0;
        else if (issue_mul) cnt <= CNT_W'(MUL_CYCLES - 1);
`ifdef EXEC_DIV_EN
        else if (issue_div) cnt <= CNT_W'(32);
`endif
        else if (busy && cnt != '0) cnt <= cnt - 1'b1;
    end

    assign mul_signed  = (idex.md_op == MD_MULT);
    assign mul_a_ext   = {{32{mul_signed & idex.src_a[31]}}, idex.src_a};
    assign mul_b_ext   = {{32{mul_signed & idex.src_b[31]}}, idex.src_b};
    assign mul_product = mul_a_ext * mul_b_ext;

    // NOTE: the product chain is pure datapath and is left unreset; the FSM decides when it is valid.
    always_ff @(posedge clk) begin
        if (issue_mul) mul_chain[0] <= mul_product;
        for (int i = 1; i < MUL_CYCLES; i++) mul_chain[i] <= mul_chain[i-1];
    end

`ifdef EXEC_DIV_EN
    assign div_signed = (idex.md_op == MD_DIV);
    assign div_a_neg  = div_signed & idex.src_a[31];
    assign div_b_neg  = div_signed & idex.src_b[31];
    assign div_a_mag  = div_a_neg ? 32'd0 - idex.src_a : idex.src_a;
    assign div_b_mag  = div_b_neg ? 32'd0 - idex.src_b : idex.src_b;
    assign div_shift  = {div_rem, div_quo[31]};
    assign div_diff   = div_shift - {1'b0, div_dvsr};

    // Restoring division on magnitudes: quotient bits shift in where the dividend shifts out.
    always_ff @(posedge clk) begin
        if (issue_div) begin
            div_quo   <= div_a_mag;
            div_rem   <= '0;
            div_dvsr  <= div_b_mag;
            div_dvnd  <= idex.src_a;
            div_q_neg <= div_a_neg ^ div_b_neg;
            div_r_neg <= div_a_neg;
        end else if (state == S_DIV && cnt != '0) begin
            if (!div_diff[32]) begin
                div_rem <= div_diff[31:0];
                div_quo <= {div_quo[30:0], 1'b1};
            end else begin
                div_rem <= div_shift[31:0];
                div_quo <= {div_quo[30:0], 1'b0};
            end
        end
    end

    always_comb begin
        if (div_dvsr == '0) begin
            div_lo = '1;
            div_hi = div_dvnd;
        end else begin
            div_lo = div_q_neg ? 32'd0 - div_quo : div_quo;
            div_hi = div_r_neg ? 32'd0 - div_rem : div_rem;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else if (mul_done) begin
            {hi, lo} <= mul_chain[MUL_CYCLES-1];
`ifdef EXEC_DIV_EN
        end else if (div_done) begin
            hi <= div_hi;
            lo <= div_lo;
`endif
        end else if (!stall_e && idex.md_op == MD_MTHI) begin
            hi <= idex.src_a;
        end else if (!stall_e && idex.md_op == MD_MTLO) begin
            lo <= idex.src_a;
        end
    end

    always_comb begin
        alu_result = '0;
        case (idex.alu_ctrl)
            ALU_AND:  alu_result = idex.src_a & idex.src_b;
            ALU_OR:   alu_result = idex.src_a | idex.src_b;
            ALU_ADD:  alu_result = idex.src_a + idex.src_b;
            ALU_XOR:  alu_result = idex.src_a ^ idex.src_b;
            ALU_NOR:  alu_result = ~(idex.src_a | idex.src_b);
            ALU_SUB:  alu_result = idex.src_a - idex.src_b;
            ALU_SLT:  alu_result = {31'd0, $signed(idex.src_a) < $signed(idex.src_b)};
            ALU_SLTU: alu_result = {31'd0, idex.src_a < idex.src_b};
            ALU_SLL:  alu_result = idex.src_b << idex.shamt;
            ALU_SRL:  alu_result = idex.src_b >> idex.shamt;
            ALU_SRA:  alu_result = $signed(idex.src_b) >>> idex.shamt;
            ALU_LUI:  alu_result = {idex.src_b[15:0], 16'h0000};
            ALU_MFHI: alu_result = hi;
            ALU_MFLO: alu_result = lo;
            default:  alu_result = '0;
        endcase
    end

    // A stalled instruction is sent to MEM as a bubble; it stays in ID/EX.
    assign reg_write_e   = idex.reg_write  & ~stall_e;
    assign mem_to_reg_e  = idex.mem_to_reg & ~stall_e;
    assign mem_write_e   = idex.mem_write  & ~stall_e;
    assign branch_e      = idex.branch     & ~stall_e;
    assign alu_out_e     = alu_result;
    assign zero_e        = (alu_result == '0);
    assign write_data_e  = idex.rt_data;
    assign write_reg_e   = idex.write_reg;
    assign pc_branch_e   = idex.pc_plus4 + (idex.imm << 2);
    assign jump_addr_e   = {idex.pc_plus4[31:28], idex.instr_index, 2'b00};
    assign branch_type_e = idex.branch_type;

endmodule
